// File: rtl/fix_pkg.sv
// Shared types and ASCII constants for the FIX field assembly path.
// Imported by the tag accumulator and by the field assembler.
package fix_pkg;

    typedef enum logic [1:0] {
        K_TAG_BYTE = 2'd0,
        K_TAG_END  = 2'd1,
        K_VAL_BYTE = 2'd2,
        K_VAL_END  = 2'd3
    } kind_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TAG,
        S_VALUE,
        S_HOLD
    } state_t;

    localparam logic [7:0] SOH  = 8'h01;
    localparam logic [7:0] EQ   = 8'h3D;
    localparam logic [7:0] ZERO = 8'h30;
    localparam logic [7:0] NINE = 8'h39;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ZERO) && (b <= NINE);
    endfunction

endpackage

// File: rtl/fix_tag_accum.sv
// One decimal step of the tag number: acc*10 + digit, with digit check and
// saturation at all-ones when the result no longer fits in TAG_W bits.
module fix_tag_accum
    import fix_pkg::*;
#(
    parameter int TAG_W = 16
) (
    input  logic [TAG_W-1:0] acc_i,
    input  logic [7:0]       data_i,
    output logic [TAG_W-1:0] acc_o,
    output logic             err_o
);

    // Four spare bits hold acc*10 + 9 for any TAG_W-bit accumulator.
    logic [TAG_W+3:0] wide;

    always_comb begin
        wide  = ({4'd0, acc_i} * (TAG_W+4)'(10)) + (TAG_W+4)'(data_i - ZERO);
        acc_o = acc_i;
        err_o = 1'b0;
        if (!is_digit(data_i)) begin
            err_o = 1'b1;
        end else if (wide > {4'd0, {TAG_W{1'b1}}}) begin
            acc_o = '1;
            err_o = 1'b1;
        end else begin
            acc_o = wide[TAG_W-1:0];
        end
    end

endmodule

// File: rtl/fix_field_assembler.sv
// Assembles one FIX tag=value field from the classified byte stream and
// holds it on a valid/ready output until the decoder takes it.
module fix_field_assembler
    import fix_pkg::*;
#(
    parameter int TAG_W   = 16,
    parameter int MAX_VAL = 16,
    parameter int LEN_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  kind_t                in_kind,
    input  logic [7:0]           in_data,
    output logic                 field_valid,
    input  logic                 field_ready,
    output logic [TAG_W-1:0]     field_tag,
    output logic [LEN_W-1:0]     field_len,
    output logic [MAX_VAL*8-1:0] field_val,
    output logic                 field_err
);

    state_t               state_q;
    logic [TAG_W-1:0]     tag_q;
    logic [LEN_W-1:0]     len_q;
    logic [MAX_VAL*8-1:0] val_q;
    logic                 err_q;
    logic                 valid_q;

    logic [TAG_W-1:0]     tag_d;
    logic                 tag_err;
    logic                 accept;
    logic                 handoff;
    logic                 len_full;

    function automatic logic [MAX_VAL*8-1:0] put_byte(
        input logic [MAX_VAL*8-1:0] vbuf,
        input logic [LEN_W-1:0]     idx,
        input logic [7:0]           b
    );
        logic [MAX_VAL*8-1:0] r;
        r = vbuf;
        for (int i = 0; i < MAX_VAL; i++) begin
            if (idx == LEN_W'(i)) r[i*8 +: 8] = b;
        end
        return r;
    endfunction

    // The first tag digit starts from zero rather than the previous field's tag.
    fix_tag_accum #(.TAG_W(TAG_W)) u_tag_accum (
        .acc_i  ((state_q == S_IDLE) ? '0 : tag_q),
        .data_i (in_data),
        .acc_o  (tag_d),
        .err_o  (tag_err)
    );

    assign in_ready = !valid_q;
    assign accept   = in_valid && in_ready;
    assign handoff  = valid_q && field_ready;
    assign len_full = (len_q >= LEN_W'(MAX_VAL));

    // The working registers freeze in HOLD and double as the output snapshot.
    assign field_valid = valid_q;
    assign field_tag   = tag_q;
    assign field_len   = len_q;
    assign field_val   = val_q;
    assign field_err   = err_q;

    // NOTE: every register below uses <= so all of them update from the same
    // pre-edge values; a blocking = here would let later lines see new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            len_q   <= '0;
            // NOTE: the value buffer is reset too, because it is visible on
            // field_val and must read as zero out of reset.
            val_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    case (in_kind)
                        K_TAG_BYTE: begin
                            state_q <= S_TAG;
                            tag_q   <= tag_d;
                            err_q   <= tag_err;
                            len_q   <= '0;
                            val_q   <= '0;
                        end
                        K_TAG_END: begin
                            state_q <= S_VALUE;
                            tag_q   <= '0;
                            err_q   <= 1'b1;
                            len_q   <= '0;
                            val_q   <= '0;
                        end
                        default: ; // value events before any tag are resync noise
                    endcase
                end
                S_TAG: if (accept) begin
                    case (in_kind)
                        K_TAG_BYTE: begin
                            tag_q <= tag_d;
                            if (tag_err) err_q <= 1'b1;
                        end
                        K_TAG_END: state_q <= S_VALUE;
                        K_VAL_BYTE: begin
                            state_q <= S_VALUE;
                            err_q   <= 1'b1;
                            val_q   <= put_byte(val_q, len_q, in_data);
                            len_q   <= len_q + LEN_W'(1);
                        end
                        default: begin
                            state_q <= S_HOLD;
                            err_q   <= 1'b1;
                            valid_q <= 1'b1;
                        end
                    endcase
                end
                S_VALUE: if (accept) begin
                    case (in_kind)
                        K_VAL_BYTE: begin
                            if (len_full) begin
                                err_q <= 1'b1;
                            end else begin
                                val_q <= put_byte(val_q, len_q, in_data);
                                len_q <= len_q + LEN_W'(1);
                            end
                        end
                        K_VAL_END: begin
                            state_q <= S_HOLD;
                            valid_q <= 1'b1;
                        end
                        default: err_q <= 1'b1;
                    endcase
                end
                default: begin
                    if (handoff) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fix_field_assembler.sv
// Self-checking bench: table of tag/value vectors plus hand-written stall and
// reset sequences; expected fields go through a scoreboard queue.
module tb_fix_field_assembler;
    import fix_pkg::*;

    localparam int TAG_W   = 16;
    localparam int MAX_VAL = 16;
    localparam int LEN_W   = 5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    kind_t                in_kind = K_TAG_BYTE;
    logic [7:0]           in_data = 8'h00;
    logic                 field_valid;
    logic                 field_ready = 1'b1;
    logic [TAG_W-1:0]     field_tag;
    logic [LEN_W-1:0]     field_len;
    logic [MAX_VAL*8-1:0] field_val;
    logic                 field_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [LEN_W-1:0]     len;
        logic [MAX_VAL*8-1:0] val;
        logic                 err;
    } field_t;

    typedef struct packed {
        logic [8*8-1:0]   tag_b;
        logic [7:0]       tag_n;
        logic [8*20-1:0]  val_b;
        logic [7:0]       val_n;
        logic [TAG_W-1:0] exp_tag;
        logic [LEN_W-1:0] exp_len;
        logic             exp_err;
    } vec_t;

    field_t sb_q[$];
    vec_t   vecs[9];

    fix_field_assembler #(.TAG_W(TAG_W), .MAX_VAL(MAX_VAL), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .in_data     (in_data),
        .field_valid (field_valid),
        .field_ready (field_ready),
        .field_tag   (field_tag),
        .field_len   (field_len),
        .field_val   (field_val),
        .field_err   (field_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string t, input string v, input int et, input int el, input bit ee);
        vec_t r;
        r = '0;
        for (int k = 0; k < t.len(); k++) r.tag_b[k*8 +: 8] = t[k];
        for (int k = 0; k < v.len(); k++) r.val_b[k*8 +: 8] = v[k];
        r.tag_n   = 8'(t.len());
        r.val_n   = 8'(v.len());
        r.exp_tag = TAG_W'(et);
        r.exp_len = LEN_W'(el);
        r.exp_err = ee;
        return r;
    endfunction

    // Drive one event; it transfers on the next rising edge. Returns #1 after it.
    task automatic send(input kind_t k, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, expected 1", n);
        end else begin
            in_valid = 1'b1;
            in_kind  = k;
            in_data  = d;
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        field_t e;
        e = '0;
        for (int k = 0; k < int'(v.tag_n); k++) send(K_TAG_BYTE, v.tag_b[k*8 +: 8]);
        send(K_TAG_END, 8'h00);
        for (int k = 0; k < int'(v.val_n); k++) begin
            send(K_VAL_BYTE, v.val_b[k*8 +: 8]);
            if (k < MAX_VAL) e.val[k*8 +: 8] = v.val_b[k*8 +: 8];
        end
        e.tag = v.exp_tag;
        e.len = v.exp_len;
        e.err = v.exp_err;
        sb_q.push_back(e);
        send(K_VAL_END, 8'h00);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", 128'(sb_q.size()), 128'd0);
    endtask

    // Monitor: a handoff happens on the next rising edge; compare it now.
    always @(negedge clk) begin
        if (rst_n && field_valid && field_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_field: got tag=%0d len=%0d err=%0b, expected no field",
                         field_tag, field_len, field_err);
            end else begin
                field_t e;
                e = sb_q.pop_front();
                check("field_tag", 128'(field_tag), 128'(e.tag));
                check("field_len", 128'(field_len), 128'(e.len));
                check("field_val", field_val, e.val);
                check("field_err", 128'(field_err), 128'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk("35",    "D",                    35,    1,  1'b0);
        vecs[1] = mk("8",     "FIX.4.2",              8,     7,  1'b0);
        vecs[2] = mk("9",     "ABCDEFGHIJKLMNOPQRST", 9,     16, 1'b1);
        vecs[3] = mk("99999", "1",                    65535, 1,  1'b1);
        vecs[4] = mk("3A",    "x",                    3,     1,  1'b1);
        vecs[5] = mk("49",    "",                     49,    0,  1'b0);
        vecs[6] = mk("65535", "Z",                    65535, 1,  1'b0);
        vecs[7] = mk("65536", "Z",                    65535, 1,  1'b1);
        vecs[8] = mk("1",     "0123456789ABCDEF",     1,     16, 1'b0);

        // Reset values
        #3;
        check("rst_field_valid", 128'(field_valid), 128'd0);
        check("rst_in_ready",    128'(in_ready),    128'd1);
        check("rst_field_tag",   128'(field_tag),   128'd0);
        check("rst_field_len",   128'(field_len),   128'd0);
        check("rst_field_val",   field_val,         128'd0);
        check("rst_field_err",   128'(field_err),   128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors: field_valid must rise one cycle after VAL_END
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
            check($sformatf("latency_valid_%0d", i), 128'(field_valid), 128'd1);
            check($sformatf("latency_in_ready_%0d", i), 128'(in_ready), 128'd0);
            wait_drain();
        end

        // Stall in HOLD: outputs frozen, input blocked
        field_ready = 1'b0;
        run_vec(vecs[1]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid",    128'(field_valid), 128'd1);
            check("stall_in_ready", 128'(in_ready),    128'd0);
            check("stall_tag",      128'(field_tag),   128'd8);
            check("stall_len",      128'(field_len),   128'd7);
        end
        @(posedge clk);
        #1 field_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_handoff_valid",    128'(field_valid), 128'd0);
        check("post_handoff_in_ready", 128'(in_ready),    128'd1);
        wait_drain();

        // Value events in IDLE dropped; empty tag then "X"
        send(K_VAL_BYTE, "Q");
        send(K_VAL_END, 8'h00);
        sb_q.push_back('{tag: '0, len: LEN_W'(1), val: 128'h58, err: 1'b1});
        send(K_TAG_END, 8'h00);
        send(K_VAL_BYTE, "X");
        send(K_VAL_END, 8'h00);
        wait_drain();

        // Reset mid-value: partial field must vanish
        send(K_TAG_BYTE, "3");
        send(K_TAG_BYTE, "5");
        send(K_TAG_END, 8'h00);
        send(K_VAL_BYTE, "A");
        send(K_VAL_BYTE, "B");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid",    128'(field_valid), 128'd0);
        check("midrst_in_ready", 128'(in_ready),    128'd1);
        check("midrst_tag",      128'(field_tag),   128'd0);
        check("midrst_len",      128'(field_len),   128'd0);
        check("midrst_val",      field_val,         128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk("10", "5", 10, 1, 1'b0));
        wait_drain();

        // Reset while holding a field
        field_ready = 1'b0;
        send(K_TAG_BYTE, "2");
        send(K_TAG_END, 8'h00);
        send(K_VAL_BYTE, "Q");
        send(K_VAL_END, 8'h00);
        check("hold_before_rst_valid", 128'(field_valid), 128'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("holdrst_valid", 128'(field_valid), 128'd0);
        check("holdrst_err",   128'(field_err),   128'd0);
        check("holdrst_val",   field_val,         128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        field_ready = 1'b1;
        run_vec(mk("7", "ok", 7, 2, 1'b0));
        wait_drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
